seq_priority_encoder: RTL and testbench

Parametrised, sequential successor to the team's 4-input one-hot encoder. It accepts an N-bit request vector through a valid/ready handshake and stores it. It then emits the binary index of every set bit, one per cycle, lowest index first, on a second valid/ready handshake. An optional one-hot mode rejects vectors with more than one bit set. It sits between request-generating logic (interrupt lines, channel flags) and a consumer that processes one channel index at a time.

---
 rtl/seq_priority_encoder.sv | 92 +++++++++
 tb/tb_seq_priority_encoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: accepts an N-bit request vector over a
// valid/ready handshake, then emits the index of each set bit, lowest first,
// one per output transfer. Optional one-hot mode rejects multi-bit vectors.
module seq_priority_encoder #(
  parameter int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         onehot_mode_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] in_vec_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_idx_o,
  output logic         out_last_o,
  output logic         zero_pulse_o,
  output logic         err_pulse_o,
  output logic         busy_o
);

  typedef enum logic {StIdle, StDrain} state_e;

  state_e       state_q;
  logic [N-1:0] pend_q;
  logic         zero_q;
  logic         err_q;

  logic         accept;
  logic         transfer;
  logic         in_multi;
  logic [N-1:0] pend_rest;

  // Handshake qualifiers and bit-trick helpers (x & (x-1) clears the lowest set bit).
  always_comb begin
    in_ready_o  = (state_q == StIdle);
    out_valid_o = (state_q == StDrain);
    busy_o      = (state_q == StDrain);
    accept      = in_valid_i & in_ready_o;
    transfer    = out_valid_o & out_ready_i;
    in_multi    = (in_vec_i & (in_vec_i - N'(1))) != '0;
    pend_rest   = pend_q & (pend_q - N'(1));
    out_last_o  = out_valid_o & (pend_rest == '0);
  end

  // Lowest-set-bit index of pend; scanning downward lets the lowest bit win.
  always_comb begin
    out_idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) out_idx_o = W'(i);
    end
  end

  // FSM, pending-vector register and registered status pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pend_q  <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      zero_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (in_vec_i == '0) begin
              zero_q <= 1'b1;
            end else if (onehot_mode_i && in_multi) begin
              err_q <= 1'b1;
            end else begin
              pend_q  <= in_vec_i;
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (transfer) begin
            pend_q <= pend_rest;
            if (out_last_o) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign zero_pulse_o = zero_q;
  assign err_pulse_o  = err_q;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Randomised bench for seq_priority_encoder with an N=8 and an N=5 instance,
// checked against a list-based model of the expected index stream.
module tb_seq_priority_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: N=8
  logic       oh_a = 1'b0, iv_a = 1'b0, ir_a, ov_a, ordy_a = 1'b0;
  logic [7:0] vec_a = '0;
  logic [2:0] idx_a;
  logic       last_a, zp_a, ep_a, busy_a;
  // Instance B: N=5
  logic       oh_b = 1'b0, iv_b = 1'b0, ir_b, ov_b, ordy_b = 1'b0;
  logic [4:0] vec_b = '0;
  logic [2:0] idx_b;
  logic       last_b, zp_b, ep_b, busy_b;

  seq_priority_encoder #(.N(8)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .onehot_mode_i(oh_a), .in_valid_i(iv_a), .in_ready_o(ir_a),
    .in_vec_i(vec_a), .out_valid_o(ov_a), .out_ready_i(ordy_a), .out_idx_o(idx_a),
    .out_last_o(last_a), .zero_pulse_o(zp_a), .err_pulse_o(ep_a), .busy_o(busy_a)
  );

  seq_priority_encoder #(.N(5)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .onehot_mode_i(oh_b), .in_valid_i(iv_b), .in_ready_o(ir_b),
    .in_vec_i(vec_b), .out_valid_o(ov_b), .out_ready_i(ordy_b), .out_idx_o(idx_b),
    .out_last_o(last_b), .zero_pulse_o(zp_b), .err_pulse_o(ep_b), .busy_o(busy_b)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic ir, ov, last, zp, ep, bsy;
    int   idx;
  } obs_t;

  task automatic sample(input int w, output obs_t o);
    if (w == 0) begin
      o.ir = ir_a; o.ov = ov_a; o.last = last_a; o.zp = zp_a; o.ep = ep_a; o.bsy = busy_a;
      o.idx = int'(idx_a);
    end else begin
      o.ir = ir_b; o.ov = ov_b; o.last = last_b; o.zp = zp_b; o.ep = ep_b; o.bsy = busy_b;
      o.idx = int'(idx_b);
    end
  endtask

  task automatic set_in(input int w, input logic v, input logic [63:0] vec, input logic oh);
    if (w == 0) begin
      iv_a = v; vec_a = vec[7:0]; oh_a = oh;
    end else begin
      iv_b = v; vec_b = vec[4:0]; oh_b = oh;
    end
  endtask

  task automatic set_ordy(input int w, input logic r);
    if (w == 0) ordy_a = r;
    else ordy_b = r;
  endtask

  function automatic logic [63:0] rand_vec(input int n);
    logic [63:0] v;
    logic [63:0] mask;
    mask = (64'd1 << n) - 64'd1;
    case ($urandom_range(5))
      0:       v = '0;
      1:       v = 64'd1 << $urandom_range(n - 1);
      2:       v = mask;
      default: v = {$urandom, $urandom};
    endcase
    return v & mask;
  endfunction

  task automatic idle_checks(input int w, input string tag);
    obs_t o;
    sample(w, o);
    check_val({tag, "_in_ready"}, o.ir, 1);
    check_val({tag, "_out_valid"}, o.ov, 0);
    check_val({tag, "_busy"}, o.bsy, 0);
  endtask

  // One full transaction: offer vec, then consume every expected index.
  // abort_at > 0 asserts reset after that many transfers.
  task automatic run_vec(input int w, input logic [63:0] vec_in, input logic oh,
                         input int stall_pct, input int abort_at);
    int          n;
    logic [63:0] v;
    int          exp_q[$];
    int          k;
    int          stalls;
    logic        r;
    obs_t        o;
    n = (w == 0) ? 8 : 5;
    v = vec_in & ((64'd1 << n) - 64'd1);

    @(negedge clk);
    idle_checks(w, "pre");
    set_in(w, 1'b1, v, oh);
    @(negedge clk);
    set_in(w, 1'b0, {$urandom, $urandom}, 1'($urandom));

    if (v == '0 || (oh && $countones(v) > 1)) begin
      sample(w, o);
      check_val("zero_pulse", o.zp, (v == '0) ? 1 : 0);
      check_val("err_pulse", o.ep, (v != '0) ? 1 : 0);
      check_val("rej_out_valid", o.ov, 0);
      check_val("rej_in_ready", o.ir, 1);
      @(negedge clk);
      sample(w, o);
      check_val("pulse_gone", longint'(o.zp) + longint'(o.ep), 0);
      check_val("rej_no_out", o.ov, 0);
      return;
    end

    for (int i = 0; i < n; i++) if (v[i]) exp_q.push_back(i);

    k = 0;
    stalls = 0;
    while (k < exp_q.size()) begin
      sample(w, o);
      check_val("drain_out_valid", o.ov, 1);
      check_val("drain_busy", o.bsy, 1);
      check_val("drain_in_ready", o.ir, 0);
      check_val("drain_idx", o.idx, exp_q[k]);
      check_val("drain_last", o.last, (k == exp_q.size() - 1) ? 1 : 0);
      check_val("drain_pulses", longint'(o.zp) + longint'(o.ep), 0);
      if (abort_at > 0 && k == abort_at) begin
        rst = 1'b1;
        set_ordy(w, 1'b1);
        set_in(w, 1'b0, '0, 1'b0);
        #1;
        sample(w, o);
        check_val("rst_out_valid", o.ov, 0);
        check_val("rst_busy", o.bsy, 0);
        check_val("rst_in_ready", o.ir, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          idle_checks(w, "post_rst");
        end
        return;
      end
      r = ($urandom_range(99) >= stall_pct);
      if (stalls >= 4) r = 1'b1;
      stalls = r ? 0 : stalls + 1;
      set_ordy(w, r);
      // Garbage on the input side must be ignored while draining.
      set_in(w, 1'($urandom), {$urandom, $urandom}, 1'($urandom));
      @(negedge clk);
      if (r) k++;
    end
    set_in(w, 1'b0, '0, 1'b0);
    idle_checks(w, "done");
  endtask

  initial begin
    obs_t o;
    #1;
    sample(0, o);
    check_val("reset_in_ready", o.ir, 1);
    check_val("reset_out_valid", o.ov, 0);
    check_val("reset_idx", o.idx, 0);
    check_val("reset_last", o.last, 0);
    check_val("reset_pulses", longint'(o.zp) + longint'(o.ep), 0);
    check_val("reset_busy", o.bsy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_vec(0, 64'hA4, 1'b0, 0, 0);     // 2,5,7 back to back
    run_vec(0, 64'hA4, 1'b0, 100, 0);   // maximal stalls between transfers
    run_vec(0, 64'h00, 1'b0, 0, 0);     // zero pulse
    run_vec(0, 64'h12, 1'b1, 0, 0);     // one-hot reject
    run_vec(0, 64'h80, 1'b1, 0, 0);     // bit N-1 alone
    run_vec(0, 64'hFF, 1'b0, 0, 3);     // reset after third transfer
    run_vec(0, 64'hFF, 1'b0, 30, 0);    // all ones
    run_vec(1, 64'h11, 1'b0, 0, 0);     // N=5: 0 then 4
    run_vec(1, 64'h1F, 1'b0, 20, 0);
    run_vec(1, 64'h18, 1'b1, 0, 0);

    for (int t = 0; t < 150; t++) begin
      run_vec(0, rand_vec(8), 1'($urandom), $urandom_range(60), 0);
      run_vec(1, rand_vec(5), 1'($urandom), $urandom_range(60), 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
